// File: rtl/stretch_pkg.sv
// Shared types and constants for the multi-channel pulse stretcher.
package stretch_pkg;

  typedef enum logic {
    FOLLOW = 1'b0,
    HOLD   = 1'b1
  } chan_state_e;

  localparam int unsigned DEFAULT_SYSTEM_CLOCK = 50_000_000;
  localparam int unsigned HOLD_DIVISOR         = 8;
  localparam int unsigned DEFAULT_HOLD_CLKS    = DEFAULT_SYSTEM_CLOCK / HOLD_DIVISOR;

  // The counter only ever holds HOLD_CLKS-1, but keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned hold_clks);
    int unsigned w;
    w = $clog2(hold_clks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stretch_multi_if.sv
// Channel bundle between the event sources and the stretcher.
// Handshake: none; clear and in are levels sampled every clk, out and busy are registered levels.
interface stretch_multi_if #(
  parameter int unsigned CHANNELS = 4
);

  logic                clear;
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] busy;

  modport master (
    output clear,
    output in,
    input  out,
    input  busy
  );

  modport slave (
    input  clear,
    input  in,
    output out,
    output busy
  );

endinterface

// File: rtl/stretch_chan.sv
// One stretcher channel: synchroniser, rise detect, FOLLOW/HOLD FSM and hold counter.
module stretch_chan
  import stretch_pkg::*;
#(
  parameter int unsigned HOLD_CLKS   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RETRIGGER   = 1'b1,
  parameter bit          INVERT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_raw,
  output logic out,
  output logic busy
);

  localparam int unsigned   CW     = cnt_width(HOLD_CLKS);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CLKS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   s_dly_q, s_dly_d;
  logic                   rise;
  chan_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;

  // sync_q[0] is the metastable-capture stage; the last stage is the clean level.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_raw ^ INVERT};
    s       = sync_q[SYNC_STAGES-1];
    s_dly_d = s;
    rise    = s & ~s_dly_q;
  end

  // clear leaves the synchroniser alone, so a level that is still high produces no new rise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    if (clear) begin
      state_d = FOLLOW;
      cnt_d   = '0;
      out_d   = 1'b0;
    end else begin
      case (state_q)
        FOLLOW: begin
          if (rise) begin
            out_d   = 1'b1;
            cnt_d   = RELOAD;
            state_d = HOLD;
          end else begin
            out_d = s;
          end
        end
        HOLD: begin
          out_d = 1'b1;
          if (rise && RETRIGGER) begin
            cnt_d = RELOAD;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = FOLLOW;
            out_d   = s;
          end
        end
        default: begin
          state_d = FOLLOW;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
      state_q <= FOLLOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == HOLD);

endmodule

// File: rtl/stretch_multi.sv
// Multi-channel minimum-duration pulse stretcher; one independent stretch_chan per input.
module stretch_multi
  import stretch_pkg::*;
#(
  parameter int unsigned         SYSTEM_CLOCK = DEFAULT_SYSTEM_CLOCK,
  parameter int unsigned         HOLD_CLKS    = SYSTEM_CLOCK / HOLD_DIVISOR,
  parameter int unsigned         CHANNELS     = 4,
  parameter int unsigned         SYNC_STAGES  = 2,
  parameter bit                  RETRIGGER    = 1'b1,
  parameter logic [CHANNELS-1:0] INVERT       = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  stretch_multi_if.slave  bus
);

  if (HOLD_CLKS < 1) begin : g_chk_hold
    $error("stretch_multi: HOLD_CLKS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("stretch_multi: SYNC_STAGES must be >= 2");
  end
  if (CHANNELS < 1) begin : g_chk_chan
    $error("stretch_multi: CHANNELS must be >= 1");
  end

  logic [CHANNELS-1:0] out_w;
  logic [CHANNELS-1:0] busy_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    stretch_chan #(
      .HOLD_CLKS   (HOLD_CLKS),
      .SYNC_STAGES (SYNC_STAGES),
      .RETRIGGER   (RETRIGGER),
      .INVERT      (INVERT[i])
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (bus.clear),
      .in_raw (bus.in[i]),
      .out    (out_w[i]),
      .busy   (busy_w[i])
    );
  end

  assign bus.out  = out_w;
  assign bus.busy = busy_w;

endmodule

// File: tb/tb_stretch_multi.sv
// Directed bench for stretch_multi: two instances (retrigger on/off) share one stimulus.
module tb_stretch_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_v = 1'b0;
  logic [3:0] in_v = 4'b1000;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];

  stretch_multi_if #(.CHANNELS(4)) if_r1 ();
  stretch_multi_if #(.CHANNELS(4)) if_r0 ();

  assign if_r1.clear = clear_v;
  assign if_r1.in    = in_v;
  assign if_r0.clear = clear_v;
  assign if_r0.in    = in_v;

  stretch_multi #(
    .SYSTEM_CLOCK (64),
    .HOLD_CLKS    (8),
    .CHANNELS     (4),
    .SYNC_STAGES  (2),
    .RETRIGGER    (1'b1),
    .INVERT       (4'b1000)
  ) dut_r1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_r1)
  );

  stretch_multi #(
    .SYSTEM_CLOCK (64),
    .HOLD_CLKS    (8),
    .CHANNELS     (4),
    .SYNC_STAGES  (2),
    .RETRIGGER    (1'b0),
    .INVERT       (4'b1000)
  ) dut_r0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_r0)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n   = 1'b0;
    in_v    = 4'b1000;
    clear_v = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check({tag, " r1 out"},  32'(if_r1.out),  32'h0);
    check({tag, " r1 busy"}, 32'(if_r1.busy), 32'h0);
    check({tag, " r0 out"},  32'(if_r0.out),  32'h0);
    check({tag, " r0 busy"}, 32'(if_r0.busy), 32'h0);
    rst_n = 1'b1;
  endtask

  function automatic bit win(input int e, input int lo, input int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  // Phase A expectations, hand-derived from input edges (in sampled at edge e -> rise at e+2).
  function automatic logic [3:0] exp_a_out(input int e, input bit retrig);
    logic [3:0] o;
    o[0] = win(e, 12, 19);
    o[1] = win(e, 12, 41);
    o[2] = retrig ? win(e, 12, 24) : win(e, 12, 19);
    o[3] = win(e, 32, 39);
    return o;
  endfunction

  function automatic logic [3:0] exp_a_busy(input int e, input bit retrig);
    logic [3:0] b;
    b[0] = win(e, 12, 19);
    b[1] = win(e, 12, 19);
    b[2] = retrig ? win(e, 12, 24) : win(e, 12, 19);
    b[3] = win(e, 32, 39);
    return b;
  endfunction

  function automatic logic [3:0] exp_b_out(input int e);
    logic [3:0] o;
    o    = 4'b0000;
    o[0] = win(e, 12, 14);
    o[1] = win(e, 12, 14) || win(e, 16, 41);
    return o;
  endfunction

  // driver + scoreboard
  initial begin
    logic [3:0] exp_v;

    // Phase A: short pulse, long input, retrigger on/off, inverted channel.
    do_reset("reset_a");
    for (int e = 1; e <= 50; e++) exp_q.push_back(exp_a_out(e, 1'b1));
    for (int e = 1; e <= 50; e++) begin
      in_v[0] = (e == 10);
      in_v[1] = win(e, 10, 39);
      in_v[2] = (e == 10) || (e == 15);
      in_v[3] = !(e == 30);
      tick();
      exp_v = exp_q.pop_front();
      check($sformatf("A r1 out e%0d", e),  32'(if_r1.out),  32'(exp_v));
      check($sformatf("A r1 busy e%0d", e), 32'(if_r1.busy), 32'(exp_a_busy(e, 1'b1)));
      check($sformatf("A r0 out e%0d", e),  32'(if_r0.out),  32'(exp_a_out(e, 1'b0)));
      check($sformatf("A r0 busy e%0d", e), 32'(if_r0.busy), 32'(exp_a_busy(e, 1'b0)));
    end

    // Phase B: one-cycle clear mid-hold at edge 15.
    do_reset("reset_b");
    for (int e = 1; e <= 45; e++) begin
      in_v[0] = (e == 10);
      in_v[1] = win(e, 10, 39);
      in_v[2] = 1'b0;
      in_v[3] = 1'b1;
      clear_v = (e == 15);
      tick();
      check($sformatf("B out e%0d", e),  32'(if_r1.out),  32'(exp_b_out(e)));
      check($sformatf("B busy e%0d", e), 32'(if_r1.busy),
            32'({2'b00, win(e, 12, 14), win(e, 12, 14)}));
    end
    clear_v = 1'b0;

    // Phase C: asynchronous reset in the middle of a stretch.
    do_reset("reset_c");
    for (int e = 1; e <= 14; e++) begin
      in_v[0] = (e == 10);
      tick();
    end
    check("C out before reset",  32'(if_r1.out),  32'h1);
    check("C busy before reset", 32'(if_r1.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("C out async reset",  32'(if_r1.out),  32'h0);
    check("C busy async reset", 32'(if_r1.busy), 32'h0);
    check("C r0 out async reset", 32'(if_r0.out), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("C out after release e%0d", e),  32'(if_r1.out),  32'h0);
      check($sformatf("C busy after release e%0d", e), 32'(if_r1.busy), 32'h0);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
